// File: rtl/formula_sweep_checker.sv
// Sweeps candidate assignments (binary counter or LFSR) into a formula checker
// and collects failure statistics from its combinational result.
module formula_sweep_checker #(
    parameter int VEC_W = 40,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [VEC_W-1:0] seed,
    input  logic [CNT_W-1:0] num_vecs,
    input  logic             res_i,
    output logic [VEC_W-1:0] vec_o,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [VEC_W-1:0] first_fail_vec,
    output logic             first_fail_valid,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    // Taps of x^40+x^38+x^21+x^19+1, expressed relative to the top bit.
    localparam int TAP_A = VEC_W - 1;
    localparam int TAP_B = VEC_W - 3;
    localparam int TAP_C = VEC_W - 20;
    localparam int TAP_D = VEC_W - 22;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] issued;
    logic [CNT_W-1:0] num_q;
    logic             mode_q;
    logic             accept;
    logic             sample;
    logic             more;
    logic             fb;
    logic [VEC_W-1:0] next_vec;

    assign accept = (state == S_IDLE) && start;
    assign more   = issued < num_q;
    assign sample = (state == S_RUN) && !abort;
    assign fb     = vec_o[TAP_A] ^ vec_o[TAP_B] ^ vec_o[TAP_C] ^ vec_o[TAP_D];

    always_comb begin
        next_vec = vec_o + VEC_W'(1);
        if (mode_q) next_vec = {vec_o[VEC_W-2:0], fb};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (num_vecs != '0) ? S_RUN : S_DONE;
            S_RUN: begin
                if (abort)      state_nxt = S_IDLE;
                else if (!more) state_nxt = S_DRAIN;
            end
            S_DRAIN: state_nxt = abort ? S_IDLE : S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == S_RUN) || (state == S_DRAIN);
        done      = (state == S_DONE);
        state_dbg = state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_o            <= '0;
            issued           <= '0;
            num_q            <= '0;
            mode_q           <= 1'b0;
            fail_cnt         <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            if (accept) begin
                fail_cnt         <= '0;
                first_fail_valid <= 1'b0;
                num_q            <= num_vecs;
                mode_q           <= mode;
                if (num_vecs != '0) begin
                    // An all-zero LFSR would lock up, so substitute 1.
                    vec_o  <= (mode && seed == '0) ? VEC_W'(1) : seed;
                    issued <= CNT_W'(1);
                end
            end
            if (sample) begin
                if (!res_i) begin
                    if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
                    if (!first_fail_valid) begin
                        first_fail_vec   <= vec_o;
                        first_fail_valid <= 1'b1;
                    end
                end
                if (more) begin
                    vec_o  <= next_vec;
                    issued <= issued + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_formula_sweep_checker.sv
// Directed bench for formula_sweep_checker: a reference model fills an expected
// vector queue per sweep, and the DUT output is compared once per cycle.
module tb_formula_sweep_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        mode = 1'b0;
    logic [39:0] seed = '0;
    logic [31:0] num_vecs = '0;
    logic        res_i;
    logic [39:0] vec_o;
    logic        busy;
    logic        done;
    logic [31:0] fail_cnt;
    logic [39:0] first_fail_vec;
    logic        first_fail_valid;
    logic [1:0]  state_dbg;

    int res_mode = 0;  // 0: always pass, 1: fail only on vec 0, 2: always fail
    int checks = 0;
    int errors = 0;

    logic [39:0] exp_q[$];
    logic [39:0] ffv_model = '0;
    logic        ffv_valid_model = 1'b0;
    logic [39:0] vec_model = '0;

    formula_sweep_checker dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .seed(seed), .num_vecs(num_vecs), .res_i(res_i), .vec_o(vec_o),
        .busy(busy), .done(done), .fail_cnt(fail_cnt),
        .first_fail_vec(first_fail_vec), .first_fail_valid(first_fail_valid),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic res_of(input int rm, input logic [39:0] v);
        if (rm == 0) return 1'b1;
        if (rm == 1) return v != 40'd0;
        return 1'b0;
    endfunction

    function automatic logic [39:0] model_next(input logic m, input logic [39:0] v);
        if (!m) return v + 40'd1;
        return {v[38:0], v[39] ^ v[37] ^ v[20] ^ v[18]};
    endfunction

    assign res_i = res_of(res_mode, vec_o);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_sweep(input logic m, input logic [39:0] sd, input int n,
                             input int rm, input bit poke_start);
        logic [39:0] v;
        logic [39:0] got;
        int exp_fail;
        exp_fail = 0;
        ffv_valid_model = 1'b0;
        v = (m && sd == 40'd0) ? 40'd1 : sd;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(v);
            if (!res_of(rm, v)) begin
                exp_fail++;
                if (!ffv_valid_model) begin
                    ffv_model = v;
                    ffv_valid_model = 1'b1;
                end
            end
            v = model_next(m, v);
        end
        @(negedge clk);
        mode = m; seed = sd; num_vecs = n; res_mode = rm; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            got = exp_q.pop_front();
            vec_model = got;
            chk($sformatf("run_busy[%0d]", i), 64'(busy), 64'd1);
            chk($sformatf("run_vec[%0d]", i), 64'(vec_o), 64'(got));
            chk($sformatf("run_done[%0d]", i), 64'(done), 64'd0);
            if (poke_start && i == 1) begin
                start = 1'b1; seed = 40'hAA_AAAA_AAAA; num_vecs = 7;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("drain_busy", 64'(busy), 64'd1);
        chk("drain_done", 64'(done), 64'd0);
        chk("drain_vec", 64'(vec_o), 64'(vec_model));
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_busy", 64'(busy), 64'd0);
        chk("done_fail_cnt", 64'(fail_cnt), 64'(exp_fail));
        chk("done_ffv_valid", 64'(first_fail_valid), 64'(ffv_valid_model));
        chk("done_ffv", 64'(first_fail_vec), 64'(ffv_model));
        @(negedge clk);
        chk("idle_done", 64'(done), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_vec_hold", 64'(vec_o), 64'(vec_model));
        chk("idle_fail_hold", 64'(fail_cnt), 64'(exp_fail));
    endtask

    initial begin
        // Reset with start held high: start must be ignored.
        rst = 1'b1; start = 1'b1; num_vecs = 5;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_vec", 64'(vec_o), 64'd0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_done", 64'(done), 64'd0);
        chk("post_rst_vec", 64'(vec_o), 64'd0);
        chk("post_rst_fail", 64'(fail_cnt), 64'd0);
        chk("post_rst_ffv", 64'(first_fail_vec), 64'd0);
        chk("post_rst_ffv_valid", 64'(first_fail_valid), 64'd0);

        // Counter sweep, all passing; a mid-run start must not disturb it.
        run_sweep(1'b0, 40'd0, 4, 0, 1'b1);
        // Counter wrap through all-ones to zero, failing only on zero.
        run_sweep(1'b0, 40'hFF_FFFF_FFFE, 3, 1, 1'b0);
        // LFSR from zero seed substitutes 1.
        run_sweep(1'b1, 40'd0, 3, 0, 1'b0);
        // LFSR feedback from the top bit, every vector failing.
        run_sweep(1'b1, 40'h80_0000_0000, 2, 2, 1'b0);
        // Random-seeded counter sweep with a random length.
        run_sweep(1'b0, {8'($urandom_range(0, 255)), 32'($urandom)},
                  $urandom_range(5, 20), 2, 1'b0);

        // Zero-length sweep: straight to the done pulse.
        @(negedge clk);
        num_vecs = 0; start = 1'b1; mode = 1'b0; seed = 40'h55;
        @(negedge clk);
        start = 1'b0;
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_busy", 64'(busy), 64'd0);
        chk("zero_fail", 64'(fail_cnt), 64'd0);
        chk("zero_ffv_valid", 64'(first_fail_valid), 64'd0);
        chk("zero_vec_hold", 64'(vec_o), 64'(vec_model));
        @(negedge clk);
        chk("zero_done_off", 64'(done), 64'd0);

        // Abort on the 10th RUN cycle of a 100-vector always-failing sweep.
        seed = 40'h12_3456_789A; num_vecs = 100; mode = 1'b0; res_mode = 2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            chk($sformatf("abort_vec[%0d]", i), 64'(vec_o), 64'(40'h12_3456_789A + 40'(i - 1)));
            if (i == 10) abort = 1'b1;
            @(negedge clk);
        end
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_fail", 64'(fail_cnt), 64'd9);
        chk("abort_ffv", 64'(first_fail_vec), 64'h12_3456_789A);
        chk("abort_ffv_valid", 64'(first_fail_valid), 64'd1);
        chk("abort_vec_hold", 64'(vec_o), 64'h12_3456_78A3);
        @(negedge clk);
        chk("abort_no_done", 64'(done), 64'd0);

        // Reset in the middle of a fresh sweep.
        seed = 40'h77; num_vecs = 50; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_pre_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_vec", 64'(vec_o), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_fail", 64'(fail_cnt), 64'd0);
        chk("midrst_ffv", 64'(first_fail_vec), 64'd0);
        chk("midrst_ffv_valid", 64'(first_fail_valid), 64'd0);
        @(negedge clk);
        chk("midrst_stays_idle", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/formula_sweep_checker.md
FORMULA_SWEEP_CHECKER -- requirements
Module: formula_sweep_checker

Interface
REQ-001 Parameter VEC_W, default 40: width of the candidate assignment driven into the formula checker (inputs v_1..v_40, bit 0 = v_1).
REQ-002 Parameter CNT_W, default 32: width of vector-count and fail-count registers.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin a sweep; sampled only in IDLE.
REQ-006 abort  input  1  terminate a sweep early; sampled in RUN and DRAIN.
REQ-007 mode  input  1  0 = binary counter sweep, 1 = LFSR sweep; captured at start.
REQ-008 seed  input  VEC_W  first vector of the sweep; captured at start.
REQ-009 num_vecs  input  CNT_W  number of vectors to issue; captured at start.
REQ-010 res_i  input  1  formula output o_1 for the vector currently on vec_o (combinational path through the checker).
REQ-011 vec_o  output  VEC_W  candidate assignment to the formula checker (registered).
REQ-012 busy  output  1  high in RUN and DRAIN.
REQ-013 done  output  1  one-cycle pulse at normal sweep completion.
REQ-014 fail_cnt  output  CNT_W  number of sampled vectors with res_i = 0.
REQ-015 first_fail_vec  output  VEC_W  first vector of the sweep with res_i = 0.
REQ-016 first_fail_valid  output  1  high once first_fail_vec holds a captured failure.

Function
REQ-017 FSM states IDLE, RUN, DRAIN, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-018 IDLE & start & num_vecs != 0 -> RUN; on that edge vec_o <= seed (LFSR mode with seed == 0: vec_o <= 1), issued count <= 1, fail_cnt <= 0, first_fail_valid <= 0.
REQ-019 IDLE & start & num_vecs == 0 -> DONE; fail_cnt <= 0, first_fail_valid <= 0, vec_o unchanged.
REQ-020 start while not in IDLE is ignored.
REQ-021 In RUN, each cycle res_i is evaluated against the vec_o value present that cycle; if res_i == 0: fail_cnt increments (saturating at 2^CNT_W-1) and, if first_fail_valid == 0, first_fail_vec <= vec_o and first_fail_valid <= 1.
REQ-022 In RUN, if issued count < num_vecs: vec_o advances to the next vector and issued count increments; otherwise RUN -> DRAIN.
REQ-023 Counter mode next vector = vec_o + 1 modulo 2^VEC_W (all-ones wraps to zero).
REQ-024 LFSR mode next vector = {vec_o[VEC_W-2:0], fb}, fb = XOR of vec_o bits 39, 37, 20, 18 (polynomial x^40+x^38+x^21+x^19+1); never reaches zero from a nonzero state.
REQ-025 DRAIN lasts one cycle with no sampling and no vec_o change, then -> DONE; exactly num_vecs vectors are sampled per sweep, one per cycle.
REQ-026 done = 1 only in DONE; fail_cnt, first_fail_vec, first_fail_valid, vec_o hold their values through DONE and IDLE until the next accepted start.
REQ-027 abort in RUN or DRAIN -> IDLE next edge; the vector on vec_o that cycle is not sampled; no done pulse; statistics retain values from cycles already sampled.
REQ-028 abort has priority over sampling and vec_o advance in the same cycle.

Reset
REQ-029 rst high at a clock edge forces IDLE and vec_o = 0, busy = 0, done = 0, fail_cnt = 0, first_fail_vec = 0, first_fail_valid = 0, issued count = 0, regardless of state, including mid-sweep.
REQ-030 start asserted in the same cycle as rst is ignored.

Verification
REQ-031 Counter mode, seed = 0, num_vecs = 4, res_i tied 1 -> vec_o 0,1,2,3 on consecutive cycles, busy 5 cycles, done pulse 1 cycle later, fail_cnt = 0, first_fail_valid = 0.
REQ-032 Counter mode, seed = 2^40-2, num_vecs = 3, res_i = 0 only when vec_o == 0 -> vec_o FF..FE, FF..FF, 0; fail_cnt = 1, first_fail_vec = 0, first_fail_valid = 1.
REQ-033 LFSR mode, seed = 0, num_vecs = 3 -> vec_o sequence 1, 2, 4; LFSR from seed 8000000000 (hex) next = 0000000001.
REQ-034 num_vecs = 0 with start -> done pulse next cycle, busy never high, fail_cnt = 0.
REQ-035 Counter sweep num_vecs = 100, res_i = 0 always, abort at 10th RUN cycle -> IDLE next edge, fail_cnt = 9, no done; then rst mid-sweep of a new run -> all outputs 0 next cycle.
